cpu_sequencer: RTL and testbench



---
 rtl/cpu_sequencer.sv | 158 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Control sequencer and instruction register for the single-port Harvard CPU.
// Steps FETCH -> EXEC1 -> (EXEC2), latches the instruction word during FETCH,
// and drives the decoder's one-hot state and opcode inputs. Also tracks
// run/single-step/halt control, sticky illegal-opcode flag and retire count.
module cpu_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step_mode,
  input  logic [DATA_W-1:0] mem_data,
  output logic [2:0]        state,
  output logic [3:0]        inst,
  output logic [DATA_W-5:0] operand,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic [CNT_W-1:0]  instr_count
);

  localparam int unsigned OprW = DATA_W - 4;

  localparam logic [3:0] OpLda = 4'b0000;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSub = 4'b0011;
  localparam logic [3:0] OpStp = 4'b0111;
  localparam logic [3:0] OpMax = 4'b1010; // highest defined opcode (LSR)

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec1,
    StExec2,
    StHalt
  } st_e;

  st_e              st_q, st_d;
  logic             run_q;
  logic             start;
  logic             retire;
  st_e              after_retire;
  logic [2:0]       state_d;
  logic [3:0]       inst_q;
  logic [OprW-1:0]  operand_q;
  logic [2:0]       state_q;
  logic             busy_q;
  logic             halted_q;
  logic             illegal_q;
  logic [CNT_W-1:0] count_q;
  logic             inst_illegal;
  logic             inst_two_exec;

  assign start         = run & ~run_q;
  assign inst_illegal  = (inst_q > OpMax);
  assign inst_two_exec = (inst_q == OpLda) || (inst_q == OpAdd) || (inst_q == OpSub);

  // Run request history for single-step rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q <= 1'b0;
    end else begin
      run_q <= run;
    end
  end

  // Next-state logic; retire marks the edge on which an instruction completes
  always_comb begin
    st_d         = st_q;
    retire       = 1'b0;
    // Single-step always parks in IDLE; free-run chains straight into FETCH
    after_retire = (!step_mode && run) ? StFetch : StIdle;
    unique case (st_q)
      StIdle: begin
        if (step_mode ? start : run) begin
          st_d = StFetch;
        end
      end
      StFetch: begin
        st_d = StExec1;
      end
      StExec1: begin
        if (inst_two_exec) begin
          st_d = StExec2;
        end else if (inst_q == OpStp) begin
          st_d   = StHalt;
          retire = 1'b1;
        end else begin
          // Illegal opcodes also land here and retire as a one-cycle NOP
          st_d   = after_retire;
          retire = 1'b1;
        end
      end
      StExec2: begin
        st_d   = after_retire;
        retire = 1'b1;
      end
      StHalt: begin
        if (!run) begin
          st_d = StIdle;
        end
      end
      default: begin
        st_d = StIdle;
      end
    endcase
  end

  // One-hot decoder strobe for the upcoming state; zero when idle or halted
  always_comb begin
    state_d = 3'b000;
    unique case (st_d)
      StFetch: state_d = 3'b001;
      StExec1: state_d = 3'b010;
      StExec2: state_d = 3'b100;
      default: state_d = 3'b000;
    endcase
  end

  // Sequencer state, instruction register and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q      <= StIdle;
      state_q   <= 3'b000;
      inst_q    <= OpStp; // STP keeps the decoder from asserting writes or loads
      operand_q <= '0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      st_q     <= st_d;
      state_q  <= state_d;
      busy_q   <= (state_d != 3'b000);
      halted_q <= (st_d == StHalt);
      if (st_q == StFetch) begin
        inst_q    <= mem_data[DATA_W-1 -: 4];
        operand_q <= mem_data[OprW-1:0];
      end
      if ((st_q == StExec1) && inst_illegal) begin
        illegal_q <= 1'b1;
      end
      if (retire) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign state       = state_q;
  assign inst        = inst_q;
  assign operand     = operand_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer. A second instance with a
// 4-bit counter exercises counter wrap-around in a short run.
module tb_cpu_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic        step_mode;
  logic [15:0] mem_data;
  logic [2:0]  state;
  logic [3:0]  inst;
  logic [11:0] operand;
  logic        busy;
  logic        halted;
  logic        illegal;
  logic [15:0] instr_count;

  logic        reset_w;
  logic        run_w;
  logic        step_mode_w;
  logic [15:0] mem_data_w;
  logic [2:0]  state_w;
  logic [3:0]  inst_w;
  logic [11:0] operand_w;
  logic        busy_w;
  logic        halted_w;
  logic        illegal_w;
  logic [3:0]  instr_count_w;

  int n_cmp;
  int n_bad;

  cpu_sequencer #(
    .DATA_W(16),
    .CNT_W (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .step_mode  (step_mode),
    .mem_data   (mem_data),
    .state      (state),
    .inst       (inst),
    .operand    (operand),
    .busy       (busy),
    .halted     (halted),
    .illegal    (illegal),
    .instr_count(instr_count)
  );

  cpu_sequencer #(
    .DATA_W(16),
    .CNT_W (4)
  ) dut_w (
    .clk        (clk),
    .reset      (reset_w),
    .run        (run_w),
    .step_mode  (step_mode_w),
    .mem_data   (mem_data_w),
    .state      (state_w),
    .inst       (inst_w),
    .operand    (operand_w),
    .busy       (busy_w),
    .halted     (halted_w),
    .illegal    (illegal_w),
    .instr_count(instr_count_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    reset       = 1'b1;
    run         = 1'b0;
    step_mode   = 1'b0;
    mem_data    = 16'h0000;
    reset_w     = 1'b1;
    run_w       = 1'b0;
    step_mode_w = 1'b0;
    mem_data_w  = 16'h1000;

    tick();
    tick();
    reset = 1'b0;
    check("rst_state", 32'(state), 32'h0);
    check("rst_inst", 32'(inst), 32'h7);
    check("rst_operand", 32'(operand), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_illegal", 32'(illegal), 32'h0);
    check("rst_count", 32'(instr_count), 32'h0);
    tick();
    check("idle_no_run", 32'(state), 32'h0);

    // Program LDA, ADD, STP in free-run
    run      = 1'b1;
    mem_data = 16'h0005;
    tick(); check("p1_s1", 32'(state), 32'h1);
    check("p1_busy", 32'(busy), 32'h1);
    tick(); check("p1_s2", 32'(state), 32'h2);
    check("p1_inst_lda", 32'(inst), 32'h0);
    check("p1_opr_lda", 32'(operand), 32'h005);
    mem_data = 16'h2006;
    tick(); check("p1_s3", 32'(state), 32'h4);
    tick(); check("p1_s4", 32'(state), 32'h1);
    check("p1_cnt1", 32'(instr_count), 32'h1);
    tick(); check("p1_s5", 32'(state), 32'h2);
    check("p1_inst_add", 32'(inst), 32'h2);
    check("p1_opr_add", 32'(operand), 32'h006);
    mem_data = 16'h7000;
    tick(); check("p1_s6", 32'(state), 32'h4);
    tick(); check("p1_s7", 32'(state), 32'h1);
    check("p1_cnt2", 32'(instr_count), 32'h2);
    tick(); check("p1_s8", 32'(state), 32'h2);
    tick(); check("p1_s9", 32'(state), 32'h0);
    check("halt_halted", 32'(halted), 32'h1);
    check("halt_busy", 32'(busy), 32'h0);
    check("halt_cnt3", 32'(instr_count), 32'h3);
    check("halt_inst", 32'(inst), 32'h7);
    tick(); check("halt_stay", 32'(halted), 32'h1);
    check("halt_stay_cnt", 32'(instr_count), 32'h3);

    // Leave HALT, then restart into LDI/JMP free-run
    run = 1'b0;
    tick(); check("halt_to_idle", 32'(halted), 32'h0);
    check("halt_to_idle_st", 32'(state), 32'h0);
    run      = 1'b1;
    mem_data = 16'h8003;
    tick(); check("p2_s1", 32'(state), 32'h1);
    tick(); check("p2_s2", 32'(state), 32'h2);
    check("p2_inst_ldi", 32'(inst), 32'h8);
    check("p2_opr_ldi", 32'(operand), 32'h003);
    mem_data = 16'h4000;
    tick(); check("p2_s3", 32'(state), 32'h1);
    check("p2_cnt4", 32'(instr_count), 32'h4);
    tick(); check("p2_s4", 32'(state), 32'h2);
    check("p2_inst_jmp", 32'(inst), 32'h4);
    mem_data = 16'h8003;
    tick(); check("p2_s5", 32'(state), 32'h1);
    check("p2_cnt5", 32'(instr_count), 32'h5);
    tick(); check("p2_s6", 32'(state), 32'h2);
    tick(); check("p2_s7", 32'(state), 32'h1);
    check("p2_cnt6", 32'(instr_count), 32'h6);
    check("p2_illegal0", 32'(illegal), 32'h0);

    // Illegal opcode executes as a one-cycle NOP, then LDA still takes 3 cycles
    mem_data = 16'hC123;
    tick(); check("ill_s1", 32'(state), 32'h2);
    check("ill_inst", 32'(inst), 32'hC);
    check("ill_opr", 32'(operand), 32'h123);
    check("ill_not_yet", 32'(illegal), 32'h0);
    mem_data = 16'h0005;
    tick(); check("ill_s2", 32'(state), 32'h1);
    check("ill_cnt7", 32'(instr_count), 32'h7);
    check("ill_set", 32'(illegal), 32'h1);
    tick(); check("ill_lda_e1", 32'(state), 32'h2);
    tick(); check("ill_lda_e2", 32'(state), 32'h4);
    mem_data = 16'h2006;
    tick(); check("ill_lda_done", 32'(state), 32'h1);
    check("ill_cnt8", 32'(instr_count), 32'h8);
    check("ill_sticky", 32'(illegal), 32'h1);

    // Drop run during EXEC1 of ADD: EXEC2 still runs, then IDLE
    tick(); check("drop_e1", 32'(state), 32'h2);
    run = 1'b0;
    tick(); check("drop_e2", 32'(state), 32'h4);
    tick(); check("drop_idle", 32'(state), 32'h0);
    check("drop_busy", 32'(busy), 32'h0);
    check("drop_cnt9", 32'(instr_count), 32'h9);

    // Single-step: three run pulses, three retires
    step_mode = 1'b1;
    mem_data  = 16'h1000;
    tick(); check("ss_idle0", 32'(state), 32'h0);
    for (int p = 0; p < 3; p++) begin
      run = 1'b1;
      tick(); check("ss_fetch", 32'(state), 32'h1);
      tick(); check("ss_exec1", 32'(state), 32'h2);
      tick(); check("ss_idle", 32'(state), 32'h0);
      check("ss_busy", 32'(busy), 32'h0);
      check("ss_cnt", 32'(instr_count), 32'(10 + p));
      tick(); check("ss_hold", 32'(state), 32'h0);
      run = 1'b0;
      tick();
    end
    check("ss_total", 32'(instr_count), 32'hC);

    // Asynchronous reset in the middle of EXEC2
    step_mode = 1'b0;
    run       = 1'b1;
    mem_data  = 16'h0005;
    tick(); check("ar_fetch", 32'(state), 32'h1);
    tick(); check("ar_exec1", 32'(state), 32'h2);
    tick(); check("ar_exec2", 32'(state), 32'h4);
    check("ar_cnt_pre", 32'(instr_count), 32'hC);
    #2 reset = 1'b1;
    #1;
    check("ar_state", 32'(state), 32'h0);
    check("ar_inst", 32'(inst), 32'h7);
    check("ar_cnt", 32'(instr_count), 32'h0);
    check("ar_illegal", 32'(illegal), 32'h0);
    check("ar_busy", 32'(busy), 32'h0);
    run = 1'b0;
    #1 reset = 1'b0;
    tick(); check("ar_after", 32'(state), 32'h0);
    check("ar_after_cnt", 32'(instr_count), 32'h0);

    // Counter wrap on the 4-bit instance: retire every 2 cycles
    check("w_rst_cnt", 32'(instr_count_w), 32'h0);
    reset_w = 1'b0;
    run_w   = 1'b1;
    for (int c = 0; c < 31; c++) tick();
    check("w_cnt_f", 32'(instr_count_w), 32'hF);
    check("w_state_f", 32'(state_w), 32'h1);
    tick();
    tick();
    check("w_cnt_wrap", 32'(instr_count_w), 32'h0);
    check("w_illegal", 32'(illegal_w), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
